// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared word width, PC step and prefetch FSM states
package pipeline_pkg;
  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] PC_STEP = 32'd4;
  typedef enum logic {RUN, DRAIN} pf_state_e;
endpackage

// File: rtl/prefetch_fifo.sv
// prefetch_fifo: {pc, instr} queue with flush and a registered head entry
module prefetch_fifo
  import pipeline_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH+1),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [WORD_W-1:0] push_pc,
  input  logic [WORD_W-1:0] push_instr,
  output logic [CW-1:0]     count,
  output logic [WORD_W-1:0] head_pc,
  output logic [WORD_W-1:0] head_instr
);
  logic [WORD_W-1:0] mem_pc [DEPTH];
  logic [WORD_W-1:0] mem_instr [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_nxt;
  logic load_push, load_mem;
  assign rd_nxt = rd_ptr + 1'b1;
  // head takes the incoming word when the queue is (or is becoming) empty
  assign load_push = push && (count == '0 || (pop && count == CW'(1)));
  assign load_mem = pop && count > CW'(1);
  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count <= count + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clk_i) begin
    if (push && !flush) begin
      mem_pc[wr_ptr] <= push_pc;
      mem_instr[wr_ptr] <= push_instr;
    end
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      head_pc <= '0;
      head_instr <= '0;
    end else if (!flush && load_push) begin
      head_pc <= push_pc;
      head_instr <= push_instr;
    end else if (!flush && load_mem) begin
      head_pc <= mem_pc[rd_nxt];
      head_instr <= mem_instr[rd_nxt];
    end
  end
endmodule

// File: rtl/inst_prefetch_buffer.sv
// inst_prefetch_buffer: instruction prefetch queue between imem and the IF/ID register.
// Define PREFETCH_PERF_EN to add the flush_cnt_o / empty_cnt_o performance counters.
module inst_prefetch_buffer
  import pipeline_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              redirect_i,
  input  logic [WORD_W-1:0] redirect_pc_i,
  output logic              imem_req_o,
  output logic [WORD_W-1:0] imem_addr_o,
  input  logic              imem_rvalid_i,
  input  logic [WORD_W-1:0] imem_rdata_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [WORD_W-1:0] out_pc_o,
  output logic [WORD_W-1:0] out_instr_o
`ifdef PREFETCH_PERF_EN
  ,
  output logic [31:0]       flush_cnt_o,
  output logic [31:0]       empty_cnt_o
`endif
);
  localparam int CW = $clog2(DEPTH+1);
  pf_state_e state, state_nxt;
  logic [WORD_W-1:0] fetch_pc, resp_pc;
  logic [CW-1:0] count, outstanding, discard, in_flight;
  logic rvalid_ok, push, pop;
  // responses with nothing outstanding belong to requests killed by reset
  assign rvalid_ok = imem_rvalid_i && outstanding != '0;
  assign in_flight = outstanding - CW'(rvalid_ok);
  assign pop = out_valid_o && out_ready_i;
  assign out_valid_o = count != '0;
  assign imem_addr_o = fetch_pc;
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state <= RUN;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = state == RUN ? ((redirect_i && in_flight != '0) ? DRAIN : RUN)
              : ((discard == '0 || (rvalid_ok && discard == CW'(1))) ? RUN : DRAIN);
  end
  always_comb begin
    imem_req_o = rst_ni && state == RUN && !redirect_i
              && ({1'b0, count} + {1'b0, outstanding} < (CW+1)'(DEPTH));
    push = rvalid_ok && state == RUN && !redirect_i;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      fetch_pc <= RESET_PC;
      resp_pc <= RESET_PC;
      outstanding <= '0;
      discard <= '0;
    end else begin
      fetch_pc <= redirect_i ? redirect_pc_i : imem_req_o ? fetch_pc + PC_STEP : fetch_pc;
      resp_pc <= redirect_i ? redirect_pc_i : push ? resp_pc + PC_STEP : resp_pc;
      outstanding <= outstanding + CW'(imem_req_o) - CW'(rvalid_ok);
      discard <= state == RUN ? (redirect_i ? in_flight : '0)
               : discard - CW'(rvalid_ok && discard != '0);
    end
  end
  prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .push(push),
    .pop(pop),
    .flush(redirect_i),
    .push_pc(resp_pc),
    .push_instr(imem_rdata_i),
    .count(count),
    .head_pc(out_pc_o),
    .head_instr(out_instr_o)
  );
`ifdef PREFETCH_PERF_EN
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      flush_cnt_o <= '0;
      empty_cnt_o <= '0;
    end else begin
      flush_cnt_o <= flush_cnt_o + 32'(redirect_i);
      empty_cnt_o <= empty_cnt_o + 32'(!out_valid_o && state == RUN);
    end
  end
`endif
endmodule

// File: doc/inst_prefetch_buffer.md
INST_PREFETCH_BUFFER -- requirements
Module: inst_prefetch_buffer

Interface
REQ-001 Parameter DEPTH, default 4, meaning queue entries; legal values are powers of two, 2..16.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-003 Port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst_ni, input, 1 bit: reset, synchronous and active-low.
REQ-005 Port redirect_i, input, 1 bit: taken branch, jump or jr from the pipeline; flush and refetch.
REQ-006 Port redirect_pc_i, input, 32 bits: new fetch address, sampled when redirect_i=1.
REQ-007 Port imem_req_o, output, 1 bit: fetch request to instruction memory, always accepted.
REQ-008 Port imem_addr_o, output, 32 bits: fetch address, valid when imem_req_o=1.
REQ-009 Port imem_rvalid_i, input, 1 bit: response valid; responses return in order, latency of 1 or more cycles.
REQ-010 Port imem_rdata_i, input, 32 bits: instruction word returned by memory.
REQ-011 Port out_valid_o, output, 1 bit: an entry is available to the IF/ID register.
REQ-012 Port out_ready_i, input, 1 bit: the IF/ID register accepts the entry this cycle.
REQ-013 Port out_pc_o, output, 32 bits: PC of the head entry.
REQ-014 Port out_instr_o, output, 32 bits: instruction of the head entry.

Function
REQ-015 Tracked state: fetch_pc, resp_pc, a FIFO of {pc, instr} with DEPTH entries, an outstanding counter and a discard counter, each counter $clog2(DEPTH+1) bits wide.
REQ-016 FSM states are RUN and DRAIN.
REQ-017 In RUN, imem_req_o=1 whenever count+outstanding<DEPTH; imem_addr_o=fetch_pc; on each request, fetch_pc advances by 4 (mod 2^32) and outstanding increments.
REQ-018 When imem_rvalid_i=1 in RUN without redirect, {resp_pc, imem_rdata_i} is pushed, resp_pc advances by 4 and outstanding decrements; the entry becomes visible on out_* the next cycle (latency 1).
REQ-019 A pop occurs when out_valid_o && out_ready_i; simultaneous push and pop leave count unchanged; the outstanding bound guarantees no push into a full FIFO.
REQ-020 out_valid_o = (count!=0); out_pc_o and out_instr_o are registered FIFO-head values that stay stable while out_valid_o && !out_ready_i.
REQ-021 On redirect_i in any state, the FIFO is emptied next cycle and fetch_pc and resp_pc are set to redirect_pc_i; no request is issued that cycle.
REQ-022 On redirect_i, a same-cycle pop is still counted as consumed, and a same-cycle imem_rvalid_i is discarded.
REQ-023 On redirect_i, discard is set to the in-flight responses still expected (outstanding minus any same-cycle rvalid); the FSM goes to DRAIN if that count is nonzero, else stays in RUN.
REQ-024 In DRAIN, no requests are issued and each rvalid decrements discard and outstanding without a push; when discard reaches 0 the FSM returns to RUN.
REQ-025 A redirect during DRAIN reloads fetch_pc and resp_pc only; draining continues.
REQ-026 imem_rvalid_i with outstanding=0 is ignored.

Reset
REQ-027 While rst_ni=0 at a clock edge: fetch_pc=resp_pc=RESET_PC, FIFO empty, outstanding=discard=0, state RUN, imem_req_o=0, out_valid_o=0, out_pc_o=0, out_instr_o=0.
REQ-028 Reset asserted mid-operation aborts everything; responses arriving after reset for pre-reset requests are ignored because outstanding=0.

Configuration
REQ-029 Macro PREFETCH_PERF_EN, when defined, adds 32-bit outputs flush_cnt_o (redirects taken) and empty_cnt_o (cycles with out_valid_o=0 and state RUN), both reset to 0 and wrapping at 2^32.
REQ-030 Without PREFETCH_PERF_EN, those ports and counters do not exist and behaviour is otherwise identical.

Structure
REQ-031 Shared package pipeline_pkg holds WORD_W=32, PC_STEP=4 and the prefetch state enum {RUN, DRAIN}.
REQ-032 The FIFO is a sub-module prefetch_fifo (parameter DEPTH, synchronous active-low reset, push, pop, flush, count, registered head).

Verification
REQ-033 Reset, then 1-cycle memory latency, out_ready_i=1: out_pc_o sequence is 0x0, 0x4, 0x8 on consecutive cycles, first out_valid_o 2 cycles after the first request.
REQ-034 out_ready_i=0 held, DEPTH=4: exactly 4 requests issued, then imem_req_o=0 and the head stays pc=0x0.
REQ-035 3-cycle latency, redirect to 0x100 with 3 outstanding: state DRAIN, 3 responses dropped, next imem_addr_o=0x100, next out_pc_o=0x100.
REQ-036 Redirect in the same cycle as rvalid and pop: popped entry counted as delivered, rvalid data never appears, FIFO empty next cycle.
REQ-037 fetch_pc=0xFFFF_FFFC: next address wraps to 0x0.
REQ-038 With PREFETCH_PERF_EN, 2 redirects: flush_cnt_o=2; assert rst_ni=0 and both counters read 0.
